fifo_burst_reader: RTL

- Read-side consumer for the show-ahead dual-clock sample FIFO. It sits entirely in the FIFO's read clock domain.
- Waits until a full burst of words is buffered, then streams exactly BURST_LEN words through a registered valid/ready output toward the USB (FX3) interface logic.
- Flags buffer underrun and counts completed bursts for host status reporting.

---
 rtl/fifo_burst_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side consumer for the show-ahead dual-clock sample FIFO. Waits until a
// full burst is buffered, then streams exactly BURST_LEN words through a
// registered valid/ready stage toward the FX3 interface logic. Reports FIFO
// underrun (sticky) and a wrapping count of completed bursts.
// Everything here runs in the FIFO read clock domain.

module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8192,   // 1..16383
    parameter int CNT_WIDTH  = 14
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_rdempty,
    input  logic [CNT_WIDTH-1:0]  fifo_rdusedw,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  burst_available,
    output logic                  underrun,
    output logic [15:0]           burst_count
);

    // Burst size and index of the final word, in counter width. BURST_LEN
    // never exceeds 2^CNT_WIDTH-1, so the counter never wraps.
    localparam logic [CNT_WIDTH-1:0] BURST_WORDS = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_INDEX  = CNT_WIDTH'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // waiting for a full burst to be buffered
        ST_STREAM = 2'd1,   // popping words out of the FIFO
        ST_DRAIN  = 2'd2    // all words popped, waiting for the last to be taken
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] issued;      // words popped in the current burst

    logic stage_free;    // output register can take a new word this cycle
    logic words_left;    // current burst still has words to pop
    logic burst_ready;   // a complete burst sits in the FIFO
    logic load;          // pop the FIFO head into the output register
    logic starve;        // wanted a word but the FIFO was empty
    logic accept;        // downstream takes the word held in out_data
    logic accept_last;   // downstream takes the final word of the burst

    // Handshake and pop qualification; the pop is combinational so a word
    // popped on an edge is registered on that same edge.
    assign stage_free  = !out_valid || out_ready;
    assign words_left  = (issued < BURST_WORDS);
    assign burst_ready = enable && (fifo_rdusedw >= BURST_WORDS);
    assign load        = (state == ST_STREAM) && words_left && !fifo_rdempty && stage_free;
    assign starve      = (state == ST_STREAM) && words_left &&  fifo_rdempty && stage_free;
    assign accept      = out_valid && out_ready;
    assign accept_last = accept && out_last;

    assign fifo_rdreq  = load;

    // Burst sequencing: state, word counter, burst_available and burst_count.
    always_ff @(posedge clock or negedge nReset) begin
        // NOTE: every register, including the counters, is cleared by the async
        // reset so an abandoned burst leaves no trace; state uses <= only so all
        // updates on an edge see the pre-edge values.
        if (!nReset) begin
            state           <= ST_IDLE;
            issued          <= '0;
            burst_available <= 1'b0;
            burst_count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // enable only gates the start; a running burst always completes
                    if (burst_ready) begin
                        state           <= ST_STREAM;
                        issued          <= '0;
                        burst_available <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (load) begin
                        issued <= issued + CNT_WIDTH'(1);
                        if (issued == LAST_INDEX) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept_last) begin
                        state           <= ST_IDLE;
                        burst_available <= 1'b0;
                        burst_count     <= burst_count + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered output stage: load a new word, hold under backpressure, or
    // empty out once the held word is taken with nothing to replace it.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= fifo_q;
            out_valid <= 1'b1;
            out_last  <= (issued == LAST_INDEX);
        end else if (accept) begin
            // out_data keeps the old word; only the flags drop, so no stale
            // word or bubble is ever presented as valid
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Sticky underrun flag: the FIFO ran dry while the burst still needed
    // words and the output stage could have taken one.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end
    end

endmodule
